// File: rtl/alu_accumulator.sv
// alu_accumulator: two-register ALU driven by raw pushbuttons.
// Each key is synchronized and edge-detected into a single-cycle press pulse;
// a load press writes x or y, an exec press runs one ALU operation through a
// small IDLE/EXEC/HOLD sequencer. Chain mode feeds carry and result back into x.
module alu_accumulator #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_sel,
    input  logic             key_load_n,
    input  logic             key_exec_n,
    input  logic [2:0]       operation,
    input  logic [SHIFT-1:0] shamt,
    input  logic             chain,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             valid,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [2:0]       op_q;
    logic [SHIFT-1:0] shamt_q;
    logic             chain_q;

    logic load_sync_p0, load_sync_p1, load_prev_p2, load_armed;
    logic exec_sync_p0, exec_sync_p1, exec_prev_p2, exec_armed;
    logic warm_p0, warm_p1;
    logic load_pulse, exec_pulse, exec_accept;

    logic [WIDTH-1:0] b_opnd;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // Two's-complement overflow of a + b (+cin): operands agree in sign, sum does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Shifts with out-of-range amounts pinned: logical shifts go to 0, SRA to sign fill.
    function automatic logic [WIDTH-1:0] shift_op(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [SHIFT-1:0] sh);
        logic signed [WIDTH-1:0] a_s;
        logic [31:0]             amt;
        logic                    big;
        a_s = a;
        amt = 32'(sh);
        big = (amt >= 32'(WIDTH));
        if (op == OP_SLL)
            return big ? '0 : (a << sh);
        else if (op == OP_SRL)
            return big ? '0 : (a >> sh);
        else
            return big ? {WIDTH{a[WIDTH-1]}} : $unsigned(a_s >>> sh);
    endfunction

    // A press only counts once the synchronized key has been seen released after
    // reset, so a key held through reset release stays silent until re-pressed.
    assign load_pulse  = load_armed && !load_sync_p1 && load_prev_p2;
    assign exec_pulse  = exec_armed && !exec_sync_p1 && exec_prev_p2;
    assign exec_accept = exec_pulse && !load_pulse && (state != EXEC);

    assign x_out = x_q;
    assign y_out = y_q;

    // Key synchronizers, previous-value flops and post-reset arming
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_sync_p0 <= 1'b1;
            load_sync_p1 <= 1'b1;
            load_prev_p2 <= 1'b1;
            exec_sync_p0 <= 1'b1;
            exec_sync_p1 <= 1'b1;
            exec_prev_p2 <= 1'b1;
            warm_p0      <= 1'b0;
            warm_p1      <= 1'b0;
            load_armed   <= 1'b0;
            exec_armed   <= 1'b0;
        end else begin
            load_sync_p0 <= key_load_n;
            load_sync_p1 <= load_sync_p0;
            load_prev_p2 <= load_sync_p1;
            exec_sync_p0 <= key_exec_n;
            exec_sync_p1 <= exec_sync_p0;
            exec_prev_p2 <= exec_sync_p1;
            warm_p0      <= 1'b1;
            warm_p1      <= warm_p0;
            if (warm_p1 && load_sync_p1)
                load_armed <= 1'b1;
            if (warm_p1 && exec_sync_p1)
                exec_armed <= 1'b1;
        end
    end

    // Operation fields captured when an exec press is accepted
    always_ff @(posedge clock) begin
        if (exec_accept) begin
            op_q    <= operation;
            shamt_q <= shamt;
            chain_q <= chain;
        end
    end

    // ALU: shared adder for ADD/SUB, carry-in from the carry flag in chain mode
    always_comb begin
        b_opnd  = (op_q == OP_SUB) ? ~y_q : y_q;
        cin     = chain_q ? carry : (op_q == OP_SUB);
        sum     = {1'b0, x_q} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, cin};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_ovf(x_q, b_opnd, sum[WIDTH-1:0]);
            end
            OP_AND:  alu_res = x_q & y_q;
            OP_OR:   alu_res = x_q | y_q;
            OP_XOR:  alu_res = x_q ^ y_q;
            default: alu_res = shift_op(op_q, x_q, shamt_q);
        endcase
    end

    // Sequencer and architectural registers; a load press overrides everything
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            valid    <= 1'b0;
        end else if (load_pulse) begin
            if (load_sel)
                x_q <= data_in;
            else
                y_q <= data_in;
            valid <= 1'b0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (exec_pulse)
                        state <= EXEC;
                end
                EXEC: begin
                    result   <= alu_res;
                    zero     <= (alu_res == '0);
                    carry    <= alu_c;
                    overflow <= alu_v;
                    valid    <= 1'b1;
                    if (chain_q)
                        x_q <= alu_res;
                    state <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator (WIDTH=8, SHIFT=3).
module tb_alu_accumulator;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SLL = 3'd5;
    localparam logic [2:0] SRL = 3'd6;
    localparam logic [2:0] SRA = 3'd7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_sel = 1'b0;
    logic       key_load_n = 1'b1;
    logic       key_exec_n = 1'b1;
    logic [2:0] operation = 3'd0;
    logic [2:0] shamt = 3'd0;
    logic       chain = 1'b0;
    logic [7:0] result;
    logic       zero, overflow, carry, valid;
    logic [7:0] x_out, y_out;

    int total = 0;
    int bad = 0;

    alu_accumulator #(.WIDTH(8), .SHIFT(3)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .load_sel(load_sel),
        .key_load_n(key_load_n), .key_exec_n(key_exec_n), .operation(operation),
        .shamt(shamt), .chain(chain), .result(result), .zero(zero),
        .overflow(overflow), .carry(carry), .valid(valid), .x_out(x_out), .y_out(y_out)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic sel, input logic [7:0] val);
        load_sel = sel;
        data_in = val;
        key_load_n = 1'b0;
        tick(3);
        key_load_n = 1'b1;
        tick(3);
    endtask

    task automatic do_exec(input logic [2:0] op, input logic [2:0] sh, input logic ch);
        operation = op;
        shamt = sh;
        chain = ch;
        key_exec_n = 1'b0;
        tick(4);
        key_exec_n = 1'b1;
        tick(3);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
        total++; if ({zero, overflow, carry, valid} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {zero, overflow, carry, valid}); end
        total++; if ({x_out, y_out} !== 16'h0000) begin bad++; $display("FAIL reset_xy: got %h want 0000", {x_out, y_out}); end
        reset = 1'b0;
        tick(4);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid: got %b want 0", valid); end
    endtask

    task automatic test_add_overflow();
        do_load(1'b1, 8'h7F);
        do_load(1'b0, 8'h01);
        total++; if ({x_out, y_out} !== 16'h7F01) begin bad++; $display("FAIL load_xy: got %h want 7f01", {x_out, y_out}); end
        operation = ADD; shamt = 3'd0; chain = 1'b0;
        key_exec_n = 1'b0;
        tick(3);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL add_valid_edge3: got %b want 0", valid); end
        tick(1);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL add_valid_edge4: got %b want 1", valid); end
        key_exec_n = 1'b1;
        tick(3);
        total++; if (result !== 8'h80) begin bad++; $display("FAIL add_result: got %h want 80", result); end
        total++; if ({zero, overflow, carry} !== 3'b010) begin bad++; $display("FAIL add_flags zvc: got %b want 010", {zero, overflow, carry}); end
    endtask

    task automatic test_sub();
        do_load(1'b1, 8'h05);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL load_clears_valid: got %b want 0", valid); end
        do_load(1'b0, 8'h05);
        do_exec(SUB, 3'd0, 1'b0);
        total++; if (result !== 8'h00) begin bad++; $display("FAIL sub_eq_result: got %h want 00", result); end
        total++; if ({zero, overflow, carry} !== 3'b101) begin bad++; $display("FAIL sub_eq_flags zvc: got %b want 101", {zero, overflow, carry}); end
        do_load(1'b1, 8'h00);
        do_load(1'b0, 8'h01);
        do_exec(SUB, 3'd0, 1'b0);
        total++; if (result !== 8'hFF) begin bad++; $display("FAIL sub_borrow_result: got %h want ff", result); end
        total++; if ({zero, overflow, carry} !== 3'b000) begin bad++; $display("FAIL sub_borrow_flags zvc: got %b want 000", {zero, overflow, carry}); end
    endtask

    task automatic test_logic();
        do_load(1'b1, 8'hCC);
        do_load(1'b0, 8'hAA);
        do_exec(AND, 3'd0, 1'b0);
        total++; if (result !== 8'h88) begin bad++; $display("FAIL and_result: got %h want 88", result); end
        do_exec(OR, 3'd0, 1'b0);
        total++; if (result !== 8'hEE) begin bad++; $display("FAIL or_result: got %h want ee", result); end
        do_exec(XOR, 3'd0, 1'b0);
        total++; if (result !== 8'h66) begin bad++; $display("FAIL xor_result: got %h want 66", result); end
    endtask

    task automatic test_shifts();
        do_load(1'b1, 8'h80);
        do_load(1'b0, 8'h01);
        do_exec(SUB, 3'd0, 1'b0);
        total++; if ({result, overflow, carry} !== {8'h7F, 2'b11}) begin bad++; $display("FAIL sub_ovf: got %h/%b%b want 7f/11", result, overflow, carry); end
        do_exec(SRA, 3'd7, 1'b0);
        total++; if (result !== 8'hFF) begin bad++; $display("FAIL sra_result: got %h want ff", result); end
        total++; if ({overflow, carry} !== 2'b00) begin bad++; $display("FAIL sra_flags vc: got %b want 00", {overflow, carry}); end
        do_exec(SRL, 3'd7, 1'b0);
        total++; if (result !== 8'h01) begin bad++; $display("FAIL srl_result: got %h want 01", result); end
        do_exec(SLL, 3'd7, 1'b0);
        total++; if ({result, zero, overflow, carry} !== {8'h00, 3'b100}) begin bad++; $display("FAIL sll_result: got %h/%b want 00/100", result, {zero, overflow, carry}); end
        do_exec(SLL, 3'd1, 1'b0);
        total++; if (result !== 8'h00 || zero !== 1'b1) begin bad++; $display("FAIL sll1_result: got %h z=%b want 00 z=1", result, zero); end
        do_load(1'b1, 8'h41);
        do_exec(SLL, 3'd1, 1'b0);
        total++; if (result !== 8'h82) begin bad++; $display("FAIL sll1b_result: got %h want 82", result); end
    endtask

    task automatic test_chain();
        pulse_reset();
        do_load(1'b1, 8'hFF);
        do_load(1'b0, 8'h01);
        do_exec(ADD, 3'd0, 1'b1);
        total++; if ({result, x_out} !== 16'h0000) begin bad++; $display("FAIL chain1_result_x: got %h want 0000", {result, x_out}); end
        total++; if ({zero, carry} !== 2'b11) begin bad++; $display("FAIL chain1_flags zc: got %b want 11", {zero, carry}); end
        do_exec(ADD, 3'd0, 1'b1);
        total++; if ({result, x_out, y_out} !== 24'h020201) begin bad++; $display("FAIL chain2_result_x_y: got %h want 020201", {result, x_out, y_out}); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL chain2_carry: got %b want 0", carry); end
    endtask

    task automatic test_long_hold();
        pulse_reset();
        do_load(1'b0, 8'h01);
        operation = ADD; shamt = 3'd0; chain = 1'b1;
        key_exec_n = 1'b0;
        tick(100);
        key_exec_n = 1'b1;
        tick(3);
        total++; if ({x_out, valid} !== {8'h01, 1'b1}) begin bad++; $display("FAIL long_hold_x_valid: got %h/%b want 01/1", x_out, valid); end
    endtask

    task automatic test_back_to_back();
        load_sel = 1'b1; data_in = 8'h5A;
        operation = ADD; shamt = 3'd0; chain = 1'b1;
        key_load_n = 1'b0;
        key_exec_n = 1'b0;
        tick(3);
        key_load_n = 1'b1;
        key_exec_n = 1'b1;
        tick(5);
        total++; if ({x_out, y_out} !== 16'h5A01) begin bad++; $display("FAIL same_edge_xy: got %h want 5a01", {x_out, y_out}); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL same_edge_valid: got %b want 0", valid); end
        do_exec(ADD, 3'd0, 1'b1);
        total++; if ({result, x_out, valid} !== {8'h5B, 8'h5B, 1'b1}) begin bad++; $display("FAIL after_same_edge: got %h/%h/%b want 5b/5b/1", result, x_out, valid); end
    endtask

    task automatic test_reset_exec();
        do_load(1'b1, 8'h33);
        do_load(1'b0, 8'h11);
        operation = ADD; shamt = 3'd0; chain = 1'b0;
        key_exec_n = 1'b0;
        tick(3);
        reset = 1'b1;
        #2;
        total++; if ({result, x_out, y_out} !== 24'h000000) begin bad++; $display("FAIL rst_exec_regs: got %h want 000000", {result, x_out, y_out}); end
        total++; if ({zero, overflow, carry, valid} !== 4'b0000) begin bad++; $display("FAIL rst_exec_flags: got %b want 0000", {zero, overflow, carry, valid}); end
        tick(1);
        reset = 1'b0;
        tick(10);
        total++; if ({result, valid} !== {8'h00, 1'b0}) begin bad++; $display("FAIL held_key_no_op: got %h/%b want 00/0", result, valid); end
        key_exec_n = 1'b1;
        tick(3);
        do_load(1'b1, 8'h22);
        do_exec(ADD, 3'd0, 1'b0);
        total++; if ({result, valid} !== {8'h22, 1'b1}) begin bad++; $display("FAIL repress_after_reset: got %h/%b want 22/1", result, valid); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_logic();
        test_shifts();
        test_chain();
        test_long_hold();
        test_back_to_back();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_accumulator.md
ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, result and data_in width; legal range 2..32.
REQ-002 SHALL have parameter SHIFT, default 3: shamt width.
REQ-003 SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH: operand value for loads.
REQ-006 SHALL have port load_sel  input  1: 1 = load targets x, 0 = load targets y.
REQ-007 SHALL have port key_load_n  input  1: raw active-low load pushbutton, asynchronous to clock.
REQ-008 SHALL have port key_exec_n  input  1: raw active-low execute pushbutton, asynchronous to clock.
REQ-009 SHALL have port operation  input  3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
REQ-010 SHALL have port shamt  input  SHIFT: shift amount, unsigned.
REQ-011 SHALL have port chain  input  1: 1 = accumulate mode.
REQ-012 SHALL have ports result WIDTH, zero 1, overflow 1, carry 1, valid 1, and x_out/y_out WIDTH, all outputs and all registered.

Function
REQ-013 SHALL pass each key through a two-flop synchronizer and then a previous-value flop, producing a one-cycle press pulse when the synchronized value is 0 and the previous value is 1.
REQ-014 SHALL apply a load at the 3rd rising edge after the first edge that samples the key low, giving exactly one pulse per press regardless of hold length.
REQ-015 SHALL, on a load pulse, write data_in to x (load_sel=1) or y (load_sel=0), clear valid, and force the FSM to IDLE.
REQ-016 SHALL implement FSM states IDLE, EXEC and HOLD.
REQ-016a Transitions: IDLE/HOLD -> EXEC on an exec pulse; EXEC -> HOLD unconditionally after 1 cycle; HOLD -> IDLE on a load pulse.
REQ-017 SHALL latch operation, shamt and chain on exec-pulse acceptance.
REQ-017a On the EXEC edge it SHALL register result and the flags, and set valid=1; valid is thus high one edge after the exec pulse.
REQ-018 SHALL ignore an exec pulse while in EXEC.
REQ-018a When load and exec pulses occur in the same cycle, the load SHALL win and the exec is dropped.
REQ-019 SHALL compute ADD as x+y+cin and SUB as x+~y+cin, where cin = carry flag when chain=1, and cin = 0 (ADD) or 1 (SUB) when chain=0.
REQ-019a The carry flag SHALL equal the carry-out of that addition.
REQ-019b The overflow flag SHALL equal the two's-complement signed overflow.
REQ-020 SHALL produce carry=0 and overflow=0 for AND, OR, XOR, SLL, SRL and SRA.
REQ-021 SHALL handle shamt >= WIDTH as follows: SLL and SRL give 0; SRA gives all bits equal to the sign of x.
REQ-022 SHALL set zero = (result == 0) for every operation.
REQ-023 SHALL, when chain=1, also write result into x on the EXEC edge; y is unchanged.
REQ-024 x_out and y_out SHALL continuously reflect the x and y registers.

Reset
REQ-025 SHALL, while reset=1, clear x, y, result, zero, overflow, carry and valid to 0 and hold the FSM in IDLE.
REQ-026 SHALL reset all synchronizer and previous-value flops to 1 (released), so no press pulse is generated on reset release with keys released.
REQ-027 Reset asserted in EXEC or HOLD SHALL abort the operation with no result write.
REQ-027a A key held low across reset release SHALL produce no pulse until it is released and pressed again.

Verification (WIDTH=8, SHIFT=3)
REQ-028 Load x=0x7F, load y=0x01, op=ADD, chain=0, exec -> result=0x80, overflow=1, carry=0, zero=0; valid rises exactly 4 edges after the first edge sampling key_exec_n low.
REQ-029 x=0x05, y=0x05, op=SUB -> result=0x00, zero=1, carry=1, overflow=0.
REQ-030 chain=1 from reset, x=0xFF, y=0x01, ADD twice: 1st -> result=0x00, carry=1, x_out=0x00; 2nd -> result=0x02, carry=0, x_out=0x02.
REQ-031 x=0x80, shamt=7: SRA -> 0xFF, SRL -> 0x01, SLL -> 0x00; all with carry=0 and overflow=0.
REQ-032 key_exec_n held low 100 cycles -> exactly one EXEC cycle; loads and exec presses landing on the same edge -> register loaded, valid=0, FSM IDLE.
REQ-033 Reset pulsed during EXEC -> all outputs 0 on the next sample; with key held low through reset release, no operation occurs.
